// File: rtl/corescore_pkg.sv
// Shared definitions for the corescore stream arbiter: FSM encodings,
// datapath width and source-index width.
package corescore_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned NUM_SRC_DEF = 4;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDX_W_DEF = idx_w(NUM_SRC_DEF);

endpackage

// File: rtl/corescore_skidbuf.sv
// Two-entry skid buffer carrying a byte plus end-of-message flag.
// Registered ready on the input side, one cycle of latency, full throughput.
module corescore_skidbuf
  import corescore_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_valid,
  input  logic              i_ready
);

  logic            out_valid_q;
  logic            skid_valid_q;
  logic [DATA_W:0] out_q;
  logic [DATA_W:0] skid_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (!out_valid_q || i_ready) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= i_valid;
        if (i_valid) out_q <= {i_last, i_data};
      end
    end else if (i_valid && !skid_valid_q) begin
      // Output stalled: park the in-flight beat so upstream ready can be registered.
      skid_q       <= {i_last, i_data};
      skid_valid_q <= 1'b1;
    end
  end

  assign o_ready = !skid_valid_q;
  assign o_valid = out_valid_q;
  assign o_data  = out_q[DATA_W-1:0];
  assign o_last  = out_q[DATA_W];

endmodule

// File: rtl/corescore_stream_arbiter.sv
// Round-robin, message-locked merge of NUM_SRC byte streams into one stream,
// with an idle watchdog that releases a stuck grant.
//
//   state     | meaning
//   ST_IDLE   | no grant held; searching sources round-robin from rr
//   ST_LOCKED | grant held until a tlast transfer or watchdog expiry
module corescore_stream_arbiter
  import corescore_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [8*NUM_SRC-1:0]         i_tdata,
  input  logic [NUM_SRC-1:0]           i_tvalid,
  input  logic [NUM_SRC-1:0]           i_tlast,
  output logic [NUM_SRC-1:0]           o_tready,
  output logic [7:0]                   o_tdata,
  output logic                         o_tlast,
  output logic                         o_tvalid,
  input  logic                         i_tready,
  output logic [idx_w(NUM_SRC)-1:0]    o_grant,
  output logic                         o_timeout
);

  localparam int unsigned IDX_W = idx_w(NUM_SRC);
  localparam int unsigned WD_W  = idx_w(TIMEOUT);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              timeout_q, timeout_d;

  logic [IDX_W-1:0]  grant_inc;
  logic [IDX_W-1:0]  rr_hit_idx;
  logic              rr_hit;
  logic [IDX_W:0]    cand;
  logic              sb_in_valid;
  logic              sb_in_ready;
  logic              beat_xfer;
  logic [7:0]        sb_in_data;
  logic              sb_in_last;

  assign grant_inc = (grant_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_q + IDX_W'(1);

  always_comb begin
    rr_hit     = 1'b0;
    rr_hit_idx = '0;
    cand       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = {1'b0, rr_q} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NUM_SRC)) cand = cand - (IDX_W + 1)'(NUM_SRC);
      if (!rr_hit && i_tvalid[cand[IDX_W-1:0]]) begin
        rr_hit     = 1'b1;
        rr_hit_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign sb_in_data = i_tdata[{grant_q, 3'b000} +: 8];
  assign sb_in_last = i_tlast[grant_q];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    wd_d        = wd_q;
    timeout_d   = 1'b0;
    sb_in_valid = 1'b0;
    beat_xfer   = 1'b0;
    o_tready    = '0;
    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (rr_hit) begin
          grant_d = rr_hit_idx;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        sb_in_valid       = i_tvalid[grant_q];
        o_tready[grant_q] = sb_in_ready;
        beat_xfer         = sb_in_valid && sb_in_ready;
        if (beat_xfer) begin
          wd_d = '0;
          if (sb_in_last) begin
            state_d = ST_IDLE;
            rr_d    = grant_inc;
          end
        end else if (sb_in_ready && (TIMEOUT != 0)) begin
          // A full buffer means the downstream is stalling, not the source.
          if (wd_q == WD_W'(TIMEOUT - 1)) begin
            wd_d      = '0;
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
            rr_d      = grant_inc;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  corescore_skidbuf u_skidbuf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (sb_in_data),
    .i_last  (sb_in_last),
    .i_valid (sb_in_valid),
    .o_ready (sb_in_ready),
    .o_data  (o_tdata),
    .o_last  (o_tlast),
    .o_valid (o_tvalid),
    .i_ready (i_tready)
  );

  assign o_grant   = grant_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// Directed and random checks for the corescore stream arbiter
// (four sources, watchdog shortened to 8 idle cycles).
module tb_corescore_stream_arbiter;

  localparam int NSRC = 4;
  localparam int TMO  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [8*NSRC-1:0] i_tdata;
  logic [NSRC-1:0]   i_tvalid;
  logic [NSRC-1:0]   i_tlast;
  logic [NSRC-1:0]   o_tready;
  logic [7:0]        o_tdata;
  logic              o_tlast;
  logic              o_tvalid;
  logic              i_tready;
  logic [1:0]        o_grant;
  logic              o_timeout;

  int errors = 0;
  int checks = 0;

  logic [8:0]      src_q [NSRC][$];
  logic [8:0]      sb_q  [NSRC][$];
  logic [8:0]      cap [$];
  int              cap_cyc [$];
  logic [1:0]      gq [$];
  logic [NSRC-1:0] en, fire, in_msg;
  logic            rdy_v;
  bit              rand_mode, gen_stop;
  logic [5:0]      seq [NSRC];
  int              wait_cnt [NSRC];
  int              cyc;
  int              rand_beats;
  logic            out_in_msg;
  logic [1:0]      out_cur;

  always #5 clk = ~clk;

  corescore_stream_arbiter #(.NUM_SRC(NSRC), .TIMEOUT(TMO)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_tdata   (i_tdata),
    .i_tvalid  (i_tvalid),
    .i_tlast   (i_tlast),
    .o_tready  (o_tready),
    .o_tdata   (o_tdata),
    .o_tlast   (o_tlast),
    .o_tvalid  (o_tvalid),
    .i_tready  (i_tready),
    .o_grant   (o_grant),
    .o_timeout (o_timeout)
  );

  task automatic drive();
    for (int k = 0; k < NSRC; k++) begin
      if (en[k] && src_q[k].size() > 0) begin
        i_tvalid[k]       = 1'b1;
        i_tdata[8*k +: 8] = src_q[k][0][7:0];
        i_tlast[k]        = src_q[k][0][8];
      end else begin
        i_tvalid[k]       = 1'b0;
        i_tdata[8*k +: 8] = 8'h00;
        i_tlast[k]        = 1'b0;
      end
    end
    i_tready = rdy_v;
  endtask

  task automatic sample();
    logic [1:0] ks;
    logic [8:0] exp_b;
    cyc++;
    fire = i_tvalid & o_tready;
    for (int k = 0; k < NSRC; k++) begin
      if (fire[k]) begin
        gq.push_back(o_grant);
        if (rand_mode) sb_q[k].push_back({i_tlast[k], i_tdata[8*k +: 8]});
      end
    end
    if (rand_mode) begin
      for (int k = 0; k < NSRC; k++) begin
        if (fire[k]) wait_cnt[k] = 0;
        else if (i_tvalid[k] && !in_msg[k]) begin
          for (int j = 0; j < NSRC; j++) begin
            if (j != k && fire[j] && i_tlast[j]) begin
              wait_cnt[k]++;
              checks++;
              if (wait_cnt[k] > NSRC - 1) begin
                errors++;
                $display("FAIL starvation src%0d waited %0d messages, limit %0d", k, wait_cnt[k], NSRC - 1);
              end
            end
          end
        end
      end
      checks++;
      if (o_timeout !== 1'b0) begin
        errors++;
        $display("FAIL rand_no_timeout cycle %0d o_timeout=%b expected 0", cyc, o_timeout);
      end
    end
    if (o_tvalid && i_tready) begin
      cap.push_back({o_tlast, o_tdata});
      cap_cyc.push_back(cyc);
      if (rand_mode) begin
        rand_beats++;
        ks = o_tdata[7:6];
        checks++;
        if (sb_q[ks].size() == 0) begin
          errors++;
          $display("FAIL rand_order src%0d got %h with nothing outstanding", ks, {o_tlast, o_tdata});
        end else begin
          exp_b = sb_q[ks].pop_front();
          if ({o_tlast, o_tdata} !== exp_b) begin
            errors++;
            $display("FAIL rand_order src%0d got %h expected %h", ks, {o_tlast, o_tdata}, exp_b);
          end
        end
        checks++;
        if (out_in_msg && ks !== out_cur) begin
          errors++;
          $display("FAIL interleave got src%0d inside message of src%0d", ks, out_cur);
        end
        out_in_msg = !o_tlast;
        out_cur    = ks;
      end
    end
  endtask

  task automatic step();
    logic       lst;
    logic [1:0] ks;
    @(posedge clk);
    #1;
    for (int k = 0; k < NSRC; k++) begin
      if (fire[k]) begin
        in_msg[k] = !src_q[k][0][8];
        void'(src_q[k].pop_front());
      end
    end
    if (rand_mode) begin
      rdy_v = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NSRC; k++) begin
        if (src_q[k].size() == 0 && (in_msg[k] || (!gen_stop && $urandom_range(0, 1) == 1))) begin
          lst = gen_stop || ($urandom_range(0, 2) == 0);
          ks  = 2'(k);
          src_q[k].push_back({lst, ks, seq[k]});
          seq[k] = seq[k] + 6'd1;
        end
      end
    end
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic clear_logs();
    cap.delete();
    cap_cyc.delete();
    gq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = '0;
    rdy_v = 1'b1;
    drive();
    repeat (3) @(negedge clk);
    checks++; if (o_tvalid !== 1'b0)  begin errors++; $display("FAIL reset_tvalid got %b expected 0", o_tvalid); end
    checks++; if (o_tdata !== 8'h00)  begin errors++; $display("FAIL reset_tdata got %h expected 00", o_tdata); end
    checks++; if (o_tlast !== 1'b0)   begin errors++; $display("FAIL reset_tlast got %b expected 0", o_tlast); end
    checks++; if (o_tready !== 4'h0)  begin errors++; $display("FAIL reset_tready got %b expected 0000", o_tready); end
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b expected 0", o_timeout); end
    checks++; if (o_grant !== 2'd0)   begin errors++; $display("FAIL reset_grant got %0d expected 0", o_grant); end
    rst_n = 1'b1;
    step();
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL idle_tvalid got %b expected 0", o_tvalid); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    clear_logs();
    for (int k = 0; k < NSRC; k++) src_q[k].push_back({1'b1, exp_d[k]});
    en    = '1;
    rdy_v = 1'b1;
    repeat (12) step();
    en = '0;
    checks++;
    if (cap.size() != 4) begin
      errors++; $display("FAIL rr_count got %0d beats expected 4", cap.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap[i] !== {1'b1, exp_d[i]}) begin
          errors++; $display("FAIL rr_data beat %0d got %h expected %h", i, cap[i], {1'b1, exp_d[i]});
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (cap_cyc[i] - cap_cyc[i-1] != 2) begin
          errors++; $display("FAIL rr_spacing beat %0d got %0d cycles expected 2", i, cap_cyc[i] - cap_cyc[i-1]);
        end
      end
    end
    checks++;
    if (gq.size() != 4) begin
      errors++; $display("FAIL rr_grant_count got %0d expected 4", gq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gq[i] !== 2'(i)) begin
          errors++; $display("FAIL rr_grant beat %0d got %0d expected %0d", i, gq[i], i);
        end
      end
    end
  endtask

  task automatic test_no_interleave();
    logic [8:0] exp_c [4] = '{9'h041, 9'h042, 9'h143, 9'h155};
    logic [1:0] exp_g [4] = '{2'd2, 2'd2, 2'd2, 2'd1};
    clear_logs();
    src_q[2].push_back(9'h041);
    src_q[2].push_back(9'h042);
    src_q[2].push_back(9'h143);
    src_q[1].push_back(9'h155);
    en = 4'b0100;
    step();
    en = 4'b0110;
    repeat (10) step();
    en = '0;
    checks++;
    if (cap.size() != 4 || gq.size() != 4) begin
      errors++; $display("FAIL msg_count got %0d beats %0d grants expected 4 4", cap.size(), gq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap[i] !== exp_c[i]) begin
          errors++; $display("FAIL msg_data beat %0d got %h expected %h", i, cap[i], exp_c[i]);
        end
        checks++;
        if (gq[i] !== exp_g[i]) begin
          errors++; $display("FAIL msg_grant beat %0d got %0d expected %0d", i, gq[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [8:0] exp_c [4] = '{9'h001, 9'h002, 9'h003, 9'h104};
    clear_logs();
    src_q[0].push_back(9'h001);
    src_q[0].push_back(9'h002);
    src_q[0].push_back(9'h003);
    src_q[0].push_back(9'h104);
    en    = 4'b0001;
    rdy_v = 1'b1;
    for (int i = 0; i < 10 && cap.size() == 0; i++) step();
    checks++;
    if (cap.size() == 0) begin
      errors++; $display("FAIL stall_first_beat got none expected one within 10 cycles");
    end
    rdy_v = 1'b0;
    step();
    checks++;
    if (o_tvalid !== 1'b1 || o_tdata !== 8'h02) begin
      errors++; $display("FAIL stall_start got valid=%b data=%h expected 1 02", o_tvalid, o_tdata);
    end
    repeat (4) begin
      step();
      checks++;
      if (o_tvalid !== 1'b1 || o_tdata !== 8'h02 || o_tready !== 4'b0000) begin
        errors++;
        $display("FAIL stall_hold got valid=%b data=%h tready=%b expected 1 02 0000", o_tvalid, o_tdata, o_tready);
      end
    end
    rdy_v = 1'b1;
    repeat (8) step();
    en = '0;
    checks++;
    if (cap.size() != 4) begin
      errors++; $display("FAIL stall_count got %0d beats expected 4", cap.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap[i] !== exp_c[i]) begin
          errors++; $display("FAIL stall_data beat %0d got %h expected %h", i, cap[i], exp_c[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    src_q[0].push_back(9'h077);
    src_q[0].push_back(9'h178);
    src_q[1].push_back(9'h199);
    rdy_v = 1'b1;
    en    = 4'b0001;
    step();
    en = 4'b0011;
    step();
    en = 4'b0010;
    for (int i = 0; i < TMO; i++) begin
      step();
      checks++;
      if (o_timeout !== 1'b0) begin
        errors++; $display("FAIL timeout_early idle cycle %0d got %b expected 0", i + 1, o_timeout);
      end
    end
    step();
    checks++;
    if (o_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_pulse got %b expected 1", o_timeout);
    end
    step();
    checks++;
    if (o_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_width got %b expected 0", o_timeout);
    end
    checks++;
    if (o_grant !== 2'd1 || fire[1] !== 1'b1) begin
      errors++; $display("FAIL timeout_next_grant got grant=%0d fire=%b expected 1 1", o_grant, fire[1]);
    end
    repeat (4) step();
    en = '0;
    src_q[0].delete();
    checks++;
    if (cap.size() != 2) begin
      errors++; $display("FAIL timeout_count got %0d beats expected 2", cap.size());
    end else begin
      checks++;
      if (cap[0] !== 9'h077 || cap[1] !== 9'h199) begin
        errors++; $display("FAIL timeout_data got %h %h expected 077 199", cap[0], cap[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp_c [3] = '{9'h1B0, 9'h1B2, 9'h1B3};
    clear_logs();
    src_q[3].push_back(9'h0A1);
    src_q[3].push_back(9'h0A2);
    src_q[3].push_back(9'h1A3);
    en    = 4'b1000;
    rdy_v = 1'b0;
    repeat (4) step();
    checks++;
    if (o_tvalid !== 1'b1 || o_tready !== 4'b0000 || o_grant !== 2'd3) begin
      errors++;
      $display("FAIL pre_reset got valid=%b tready=%b grant=%0d expected 1 0000 3", o_tvalid, o_tready, o_grant);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_tvalid !== 1'b0 || o_tdata !== 8'h00 || o_tlast !== 1'b0 || o_tready !== 4'b0000 || o_grant !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset got valid=%b data=%h last=%b tready=%b grant=%0d expected all zero",
               o_tvalid, o_tdata, o_tlast, o_tready, o_grant);
    end
    for (int k = 0; k < NSRC; k++) src_q[k].delete();
    in_msg = '0;
    fire   = '0;
    en     = '0;
    rdy_v  = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    clear_logs();
    src_q[0].push_back(9'h1B0);
    src_q[2].push_back(9'h1B2);
    src_q[3].push_back(9'h1B3);
    en = 4'b1101;
    step();
    checks++;
    if (o_tvalid !== 1'b0) begin
      errors++; $display("FAIL stale_beat got valid=%b data=%h expected valid 0", o_tvalid, o_tdata);
    end
    repeat (9) step();
    en = '0;
    checks++;
    if (cap.size() != 3 || gq.size() != 3) begin
      errors++; $display("FAIL post_reset_count got %0d beats %0d grants expected 3 3", cap.size(), gq.size());
    end else begin
      checks++;
      if (gq[0] !== 2'd0) begin
        errors++; $display("FAIL post_reset_first_grant got %0d expected 0", gq[0]);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cap[i] !== exp_c[i]) begin
          errors++; $display("FAIL post_reset_data beat %0d got %h expected %h", i, cap[i], exp_c[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit done;
    clear_logs();
    for (int k = 0; k < NSRC; k++) begin
      seq[k]      = '0;
      wait_cnt[k] = 0;
      sb_q[k].delete();
    end
    out_in_msg = 1'b0;
    rand_beats = 0;
    gen_stop   = 1'b0;
    en         = '1;
    rand_mode  = 1'b1;
    repeat (10000) step();
    gen_stop = 1'b1;
    done     = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      done = (in_msg == '0) && !o_tvalid;
      for (int k = 0; k < NSRC; k++) done = done && (src_q[k].size() == 0) && (sb_q[k].size() == 0);
    end
    rand_mode = 1'b0;
    en        = '0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL rand_drain got outstanding beats expected none after 400 cycles");
    end
    checks++;
    if (rand_beats < 2000) begin
      errors++; $display("FAIL rand_throughput got %0d beats expected at least 2000", rand_beats);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    fire      = '0;
    in_msg    = '0;
    en        = '0;
    rdy_v     = 1'b1;
    rand_mode = 1'b0;
    gen_stop  = 1'b0;
    cyc       = 0;
    out_in_msg = 1'b0;
    out_cur   = '0;
    rand_beats = 0;
    for (int k = 0; k < NSRC; k++) begin
      seq[k]      = '0;
      wait_cnt[k] = 0;
    end
    test_reset();
    test_round_robin();
    test_no_interleave();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit reached at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/corescore_stream_arbiter.md
CORESCORE_STREAM_ARBITER -- requirements
Module: corescore_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of byte-stream sources, range 2..64.
REQ-002 SHALL have parameter TIMEOUT, default 1023: idle cycles tolerated inside a granted packet; 0 disables the watchdog.
REQ-003 SHALL have port i_clk, input, 1: single clock for all logic.
REQ-004 SHALL have port i_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_tdata, input, 8*NUM_SRC: source bytes; source k occupies bits [8k+7:8k].
REQ-006 SHALL have port i_tvalid, input, NUM_SRC: per-source valid.
REQ-007 SHALL have port i_tlast, input, NUM_SRC: per-source end-of-message.
REQ-008 SHALL have port o_tready, output, NUM_SRC: per-source ready.
REQ-009 SHALL have port o_tdata, output, 8: merged stream byte.
REQ-010 SHALL have port o_tlast, output, 1: merged end-of-message.
REQ-011 SHALL have port o_tvalid, output, 1: merged valid.
REQ-012 SHALL have port i_tready, input, 1: downstream ready (FIFO toward USB UART).
REQ-013 SHALL have port o_grant, output, $clog2(NUM_SRC): index of the currently or last granted source.
REQ-014 SHALL have port o_timeout, output, 1: one-cycle pulse when the watchdog forces release.

Function
REQ-015 SHALL implement FSM states IDLE and LOCKED.
REQ-016 IDLE: SHALL select the first source with i_tvalid high, searching round-robin from pointer rr; on a hit, load grant=that index and enter LOCKED on the next edge; o_tready SHALL be all-zero in IDLE.
REQ-017 LOCKED: o_tready[grant] SHALL equal the skid-buffer input ready; all other o_tready bits SHALL be 0.
REQ-018 A beat transfers when i_tvalid[grant] and o_tready[grant] are both high; a transfer with i_tlast[grant]=1 SHALL return the FSM to IDLE and set rr=grant+1, wrapping to 0 at NUM_SRC.
REQ-019 Grant SHALL never change mid-message, except by watchdog.
REQ-020 Watchdog: in LOCKED, a counter SHALL increment each cycle with no transfer and clear on any transfer; on reaching TIMEOUT, SHALL pulse o_timeout, return to IDLE, set rr=grant+1, and emit no synthetic tlast.
REQ-021 Output path SHALL be a 2-entry skid buffer: 1-cycle latency from input transfer to o_tvalid, full 1-beat/cycle throughput, and o_tdata/o_tlast stable while o_tvalid=1 and i_tready=0.
REQ-022 Arbitration overhead SHALL be exactly one IDLE cycle between messages; back-to-back single-byte messages from different sources therefore sustain 1 byte per 2 cycles.
REQ-023 Simultaneous requests in IDLE SHALL resolve by round-robin order only; a source waiting behind N-1 others SHALL be granted within N-1 messages.
REQ-024 A source deasserting i_tvalid in IDLE before grant SHALL cause no transfer; grant is re-evaluated each IDLE cycle.
REQ-025 Downstream stall (i_tready=0) SHALL back-pressure only the granted source and SHALL NOT advance the watchdog while the skid buffer is full.

Reset
REQ-026 While i_rst_n=0: FSM=IDLE, rr=0, o_grant=0, watchdog=0, skid buffer empty, o_tvalid=0, o_tdata=0, o_tlast=0, o_tready=0, o_timeout=0.
REQ-027 Reset asserted mid-message SHALL discard buffered beats with no partial output after release; first post-reset grant SHALL search from source 0.

Structure
REQ-028 FSM state encodings and the index-width localparam SHALL live in the shared corescore package/header.
REQ-029 The output buffer SHALL be a sub-module corescore_skidbuf (8-bit data + last, valid/ready both sides).

Verification
REQ-030 All four sources request 1-byte messages (0x10,0x20,0x30,0x40) simultaneously after reset -> output order 0x10,0x20,0x30,0x40, o_grant 0,1,2,3.
REQ-031 Source 2 sends "ABC" with tlast on C while source 1 requests -> A,B,C contiguous, then source 1; no interleave.
REQ-032 i_tready held low 5 cycles mid-message -> o_tdata held constant, no beat lost or duplicated, o_tready[grant]=0 once buffer full.
REQ-033 TIMEOUT=8; source 0 sends one byte without tlast then idles -> o_timeout pulses after 8 idle cycles; next grant goes to source 1 if it is requesting.
REQ-034 i_rst_n pulsed low mid-message -> all outputs zero immediately; after release, no stale beat appears and the first grant searches from source 0.
REQ-035 Random valid/ready/tlast on all sources for 10k cycles -> scoreboard per-source byte order intact, messages never interleaved, no starvation beyond NUM_SRC-1 messages.
